bk_xfer_ctrl: RTL and testbench
===============================

BK_XFER_CTRL -- requirements
Module: bk_xfer_ctrl

Interface
REQ-001 SHALL have parameters: SECTOR_BITS, default 9, log2 bytes per SD sector; TO_BITS, default 20, log2 ack-timeout cycles; AUTOSAVE_DLY, default 21477270, idle cycles before autosave.
REQ-002 SHALL have ports, in this order (name, direction, width, meaning):
- clk_sys  in  1  system clock; sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ena  in  1  backup file mounted and writable.
- ram_mask  in  24  last backup-RAM byte address; 0 means no backup RAM.
- load_req  in  1  level; rising edge requests load.
- save_req  in  1  level; rising edge requests save.
- autoload  in  1  one-cycle pulse at end of ROM download.
- autosave_en  in  1  enables dirty-driven autosave.
- dirty_set  in  1  one-cycle pulse on each CPU write to backup RAM.
- sd_ack  in  1  SD host acknowledge, high for the duration of one sector.
- sd_lba  out  32  current sector index.
- sd_rd  out  1  sector read request.
- sd_wr  out  1  sector write request.
- busy  out  1  transfer in progress.
- loading  out  1  load in progress; the system holds the core in reset while high.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout flag.

Function
REQ-003 FSM states SHALL be IDLE, REQ, XFER.
REQ-004 Last sector SHALL be last = ram_mask[23:SECTOR_BITS], zero-extended to 32 bits.
REQ-005 Start conditions SHALL be evaluated in IDLE only, and only when ena=1 and ram_mask!=0; all other start events SHALL be discarded, not queued.
REQ-006 Start priority SHALL be: autoload, then load_req edge, then save_req edge, then autosave trigger.
REQ-007 On start, the block SHALL set sd_lba=0, busy=1, loading=1 for a load, raise sd_rd (load) or sd_wr (save), clear error, and enter REQ on the next cycle.
REQ-008 In REQ, the first cycle with sd_ack=1 after sd_ack=0 SHALL drop sd_rd and sd_wr in the same registered update and enter XFER.
REQ-009 In XFER, the sd_ack falling edge SHALL act as follows: if sd_lba>=last, go to IDLE, drop busy and loading, and pulse done for one cycle; otherwise increment sd_lba, re-raise the same request, and return to REQ.
REQ-010 In REQ, if no ack arrives within 2^TO_BITS cycles, the block SHALL drop sd_rd, sd_wr, busy and loading, set error=1, and return to IDLE; no done pulse SHALL be issued.
REQ-011 Edge detection SHALL use registered copies of load_req, save_req and sd_ack, sampled every cycle in every state.
REQ-012 A dirty flag SHALL be set by dirty_set; it SHALL be cleared when a save starts and when a load completes.
REQ-013 If dirty_set coincides with the clearing of the dirty flag, the set SHALL win.
REQ-014 The autosave counter SHALL count up while dirty=1, autosave_en=1, state is IDLE, and dirty_set=0; any dirty_set SHALL zero it.
REQ-015 The autosave counter SHALL raise the autosave trigger on reaching AUTOSAVE_DLY-1, then zero itself.
REQ-016 A change of ram_mask mid-transfer SHALL take effect at the next last-sector comparison.

Reset
REQ-017 On RESET_N=0, the block SHALL asynchronously force: state IDLE; sd_lba 0; sd_rd, sd_wr, busy, loading, done, error 0; dirty 0; autosave counter 0; edge registers 0.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse; a save_req or load_req held high through reset SHALL NOT start a transfer after release until it falls and rises again.

Structure
REQ-019 A shared package bk_pkg SHALL hold the state enum and the default SECTOR_BITS, TO_BITS and AUTOSAVE_DLY constants.
REQ-020 The autosave counter SHALL be a sub-module, bk_autosave_timer, with inputs dirty, enable and kick and output fire; all other logic SHALL be flat.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Save with ram_mask=0x1FFF, SD model acking 20 cycles after each request: 16 sectors, LBA 0..15, sd_wr only, one done pulse, busy low afterwards.
- autoload pulse with ram_mask=0x7FF: 4 reads, loading high from start to done, dirty ends 0.
- load_req and save_req rising in the same cycle: a load runs; the save edge is discarded; after done, no save occurs.
- Model never acks with TO_BITS=4: error=1 and sd_rd=0 16 cycles after the request; a later save with acking clears error.
- Autosave with AUTOSAVE_DLY=100: dirty_set at t0 and at t0+50 gives a save start at t0+150; a dirty_set during that save causes a second save 100 idle cycles after done.
- RESET_N low during sector 3 of 8: outputs zero immediately; save_req held high through release produces no transfer.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared types and default sizing for the backup-RAM transfer controller.
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } bk_state_t;

    localparam int BK_SECTOR_BITS  = 9;
    localparam int BK_TO_BITS      = 20;
    localparam int BK_AUTOSAVE_DLY = 21477270;

endpackage

// File: rtl/bk_sd_if.sv
// SD sector request/acknowledge bundle between the controller and the SD host.
interface bk_sd_if;

    logic [31:0] lba;
    logic        rd;
    logic        wr;
    logic        ack;

    modport master (output lba, rd, wr, input ack);
    modport slave  (input lba, rd, wr, output ack);

endinterface

// File: rtl/bk_autosave_timer.sv
// Idle-time counter: fires once the backup RAM has stayed dirty and untouched long enough.
module bk_autosave_timer
    import bk_pkg::*;
#(
    parameter int DLY = BK_AUTOSAVE_DLY
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic dirty,
    input  logic enable,
    input  logic kick,
    output logic fire
);

    localparam int W = (DLY > 1) ? $clog2(DLY) : 1;

    logic [W-1:0] cnt;
    logic         run;

    assign run  = dirty & enable & ~kick;
    assign fire = run & (cnt == W'(DLY - 1));

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (kick | fire) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bk_xfer_ctrl.sv
// Backup-RAM load/save sequencer: walks SD sectors 0..last with a req/ack handshake.
module bk_xfer_ctrl
    import bk_pkg::*;
#(
    parameter int SECTOR_BITS  = BK_SECTOR_BITS,
    parameter int TO_BITS      = BK_TO_BITS,
    parameter int AUTOSAVE_DLY = BK_AUTOSAVE_DLY
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ena,
    input  logic [23:0] ram_mask,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        autoload,
    input  logic        autosave_en,
    input  logic        dirty_set,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        busy,
    output logic        loading,
    output logic        done,
    output logic        error
);

    bk_state_t          state;
    logic [TO_BITS-1:0] to_cnt;
    logic [31:0]        last;
    logic               load_q, save_q, ack_q, live;
    logic               load_edge, save_edge, ack_rise, ack_fall;
    logic               can_go, go, go_load, fin, dirty_clr;
    logic               dirty, fire, as_en;

    assign last = 32'(ram_mask[23:SECTOR_BITS]);

    // live blocks edges on the first cycle after reset, so a held request never fires
    always_comb begin
        load_edge = live & load_req & ~load_q;
        save_edge = live & save_req & ~save_q;
        ack_rise  = sd_ack & ~ack_q;
        ack_fall  = ~sd_ack & ack_q;
        can_go    = (state == IDLE) & ena & (ram_mask != '0);
        go_load   = can_go & (autoload | load_edge);
        go        = can_go & (autoload | load_edge | save_edge | fire);
        fin       = (state == XFER) & ack_fall & (sd_lba >= last);
        dirty_clr = (go & ~go_load) | (fin & loading);
        as_en     = autosave_en & (state == IDLE);
    end

    bk_autosave_timer #(
        .DLY(AUTOSAVE_DLY)
    ) u_autosave (
        .clk_sys(clk_sys),
        .RESET_N(RESET_N),
        .dirty  (dirty),
        .enable (as_en),
        .kick   (dirty_set),
        .fire   (fire)
    );

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            dirty <= 1'b0;
        end else if (dirty_set) begin
            dirty <= 1'b1;
        end else if (dirty_clr) begin
            dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            sd_lba  <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            busy    <= 1'b0;
            loading <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            to_cnt  <= '0;
            load_q  <= 1'b0;
            save_q  <= 1'b0;
            ack_q   <= 1'b0;
            live    <= 1'b0;
        end else begin
            load_q <= load_req;
            save_q <= save_req;
            ack_q  <= sd_ack;
            live   <= 1'b1;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state   <= REQ;
                        sd_lba  <= '0;
                        busy    <= 1'b1;
                        loading <= go_load;
                        sd_rd   <= go_load;
                        sd_wr   <= ~go_load;
                        error   <= 1'b0;
                        to_cnt  <= '0;
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end else if (to_cnt == '1) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        busy    <= 1'b0;
                        loading <= 1'b0;
                        error   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (fin) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        loading <= 1'b0;
                        done    <= 1'b1;
                    end else if (ack_fall) begin
                        // loading doubles as the operation kind for re-issue
                        sd_lba <= sd_lba + 32'd1;
                        sd_rd  <= loading;
                        sd_wr  <= ~loading;
                        to_cnt <= '0;
                        state  <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bk_xfer_ctrl.sv
// Directed plus randomized checks of bk_xfer_ctrl against a sector-list reference model.
module tb_bk_xfer_ctrl;

    localparam int SB = 9;

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic        ena_m, ena_t;
    logic [23:0] ram_mask;
    logic        load_req, save_req, autoload, autosave_en, dirty_set;
    logic        busy_m, loading_m, done_m, error_m;
    logic        busy_t, loading_t, done_t, error_t;
    bit          ack_en_m, ack_en_t, chk_load;

    bk_sd_if sd_m ();
    bk_sd_if sd_t ();

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          load_gap = 0;
    int          done_t_n = 0;
    int          k, t0, nd;
    logic        prd = 1'b0, pwr = 1'b0;
    logic [31:0] req_lba[$];
    logic        req_wr[$];
    int          req_cyc[$];
    int          done_cyc[$];

    bk_xfer_ctrl #(.SECTOR_BITS(SB), .TO_BITS(8), .AUTOSAVE_DLY(100)) dut_m (
        .clk_sys(clk_sys), .RESET_N(RESET_N), .ena(ena_m), .ram_mask(ram_mask),
        .load_req(load_req), .save_req(save_req), .autoload(autoload),
        .autosave_en(autosave_en), .dirty_set(dirty_set), .sd_ack(sd_m.ack),
        .sd_lba(sd_m.lba), .sd_rd(sd_m.rd), .sd_wr(sd_m.wr), .busy(busy_m),
        .loading(loading_m), .done(done_m), .error(error_m)
    );

    bk_xfer_ctrl #(.SECTOR_BITS(SB), .TO_BITS(4), .AUTOSAVE_DLY(100)) dut_t (
        .clk_sys(clk_sys), .RESET_N(RESET_N), .ena(ena_t), .ram_mask(ram_mask),
        .load_req(load_req), .save_req(save_req), .autoload(1'b0),
        .autosave_en(1'b0), .dirty_set(1'b0), .sd_ack(sd_t.ack),
        .sd_lba(sd_t.lba), .sd_rd(sd_t.rd), .sd_wr(sd_t.wr), .busy(busy_t),
        .loading(loading_t), .done(done_t), .error(error_t)
    );

    initial forever #5 clk_sys = ~clk_sys;
    initial forever begin
        @(posedge clk_sys);
        cyc++;
    end

    // SD host for the main instance: ack ~20 cycles after a request, 4 cycles long
    initial begin
        sd_m.ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (ack_en_m && (sd_m.rd || sd_m.wr)) begin
                repeat (19) @(negedge clk_sys);
                sd_m.ack = 1'b1;
                repeat (4) @(negedge clk_sys);
                sd_m.ack = 1'b0;
            end
        end
    end

    initial begin
        sd_t.ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (ack_en_t && (sd_t.rd || sd_t.wr)) begin
                repeat (2) @(negedge clk_sys);
                sd_t.ack = 1'b1;
                repeat (3) @(negedge clk_sys);
                sd_t.ack = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk_sys);
        if ((sd_m.rd && !prd) || (sd_m.wr && !pwr)) begin
            req_lba.push_back(sd_m.lba);
            req_wr.push_back(sd_m.wr);
            req_cyc.push_back(cyc);
        end
        if (done_m) done_cyc.push_back(cyc);
        if (chk_load && (busy_m !== loading_m)) load_gap++;
        if (done_t) done_t_n++;
        prd = sd_m.rd;
        pwr = sd_m.wr;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic clear_q();
        req_lba.delete();
        req_wr.delete();
        req_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0 = done_cyc.size();
        int j = 0;
        while (done_cyc.size() == n0 && j < budget) begin
            tick(1);
            j++;
        end
        check(tag, 32'(done_cyc.size() > n0), 1);
    endtask

    task automatic wait_reqs(input string tag, input int want, input int budget);
        int j = 0;
        while (req_lba.size() < want && j < budget) begin
            tick(1);
            j++;
        end
        check(tag, 32'(req_lba.size() >= want), 1);
    endtask

    // Reference: a transfer visits sectors 0..mask>>SB in order, one kind only
    task automatic check_xfer(input string tag, input logic [23:0] mask, input bit is_save);
        int n = int'(mask >> SB) + 1;
        check({tag, "_cnt"}, req_lba.size(), n);
        foreach (req_lba[i]) begin
            check({tag, "_lba"}, req_lba[i], i);
            check({tag, "_kind"}, 32'(req_wr[i]), 32'(is_save));
        end
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        tick(2);
        save_req = 1'b0;
        tick(1);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick(2);
        load_req = 1'b0;
        tick(1);
    endtask

    initial begin
        RESET_N = 1'b0;
        ena_m = 0; ena_t = 0; ram_mask = '0;
        load_req = 0; save_req = 0; autoload = 0;
        autosave_en = 0; dirty_set = 0;
        ack_en_m = 0; ack_en_t = 0; chk_load = 0;
        tick(3);
        check("rst_lba", sd_m.lba, 0);
        check("rst_rd", sd_m.rd, 0);
        check("rst_wr", sd_m.wr, 0);
        check("rst_busy", busy_m, 0);
        check("rst_loading", loading_m, 0);
        check("rst_done", done_m, 0);
        check("rst_error", error_m, 0);
        RESET_N = 1'b1;
        tick(2);

        // 16-sector save
        ena_m = 1; ack_en_m = 1; ram_mask = 24'h1FFF;
        clear_q();
        pulse_save();
        wait_done("s1_done", 2000);
        tick(5);
        check_xfer("s1", 24'h1FFF, 1'b1);
        check("s1_ndone", done_cyc.size(), 1);
        check("s1_busy", busy_m, 0);

        // autoload of a dirty RAM
        dirty_set = 1; tick(1); dirty_set = 0;
        ram_mask = 24'h7FF;
        clear_q();
        load_gap = 0; chk_load = 1;
        autoload = 1; tick(1); autoload = 0;
        wait_done("s2_done", 1000);
        tick(2);
        chk_load = 0;
        check_xfer("s2", 24'h7FF, 1'b0);
        check("s2_loadgap", load_gap, 0);
        check("s2_loading", loading_m, 0);
        clear_q();
        autosave_en = 1;
        tick(150);
        check("s2_dirty_clear", req_lba.size(), 0);
        autosave_en = 0;

        // simultaneous load and save edges
        ram_mask = 24'h3FF;
        clear_q();
        load_req = 1; save_req = 1;
        wait_done("s3_done", 1000);
        tick(60);
        check_xfer("s3", 24'h3FF, 1'b0);
        check("s3_ndone", done_cyc.size(), 1);
        load_req = 0; save_req = 0;
        tick(2);

        // ack timeout on the short-timeout instance
        ena_m = 0; ack_en_m = 0; ena_t = 1;
        load_req = 1;
        k = 0;
        while (!sd_t.rd && k < 10) begin
            tick(1);
            k++;
        end
        check("s4_req", sd_t.rd, 1);
        tick(15);
        check("s4_err_pre", error_t, 0);
        check("s4_rd_pre", sd_t.rd, 1);
        tick(1);
        check("s4_err", error_t, 1);
        check("s4_rd", sd_t.rd, 0);
        check("s4_busy", busy_t, 0);
        tick(10);
        check("s4_sticky", error_t, 1);
        check("s4_nodone", done_t_n, 0);
        load_req = 0;
        ack_en_t = 1;
        save_req = 1;
        tick(2);
        check("s4_clr", error_t, 0);
        check("s4_wr", sd_t.wr, 1);
        k = 0;
        while (done_t_n == 0 && k < 200) begin
            tick(1);
            k++;
        end
        check("s4_done", done_t_n, 1);
        check("s4_err_end", error_t, 0);
        save_req = 0; ena_t = 0; ack_en_t = 0;
        tick(2);

        // autosave timing
        ena_m = 1; ack_en_m = 1; ram_mask = 24'h1FF; autosave_en = 1;
        clear_q();
        tick(2);
        t0 = cyc + 1;
        dirty_set = 1; tick(1); dirty_set = 0;
        while (cyc < t0 + 49) tick(1);
        dirty_set = 1; tick(1); dirty_set = 0;
        wait_reqs("s5_req", 1, 200);
        check("s5_t", (req_cyc.size() > 0) ? req_cyc[0] : -1, t0 + 150);
        check("s5_kind", (req_wr.size() > 0) ? 32'(req_wr[0]) : 32'hX, 1);
        tick(2);
        dirty_set = 1; tick(1); dirty_set = 0;
        wait_done("s5_done1", 500);
        wait_reqs("s5_req2", 2, 300);
        check("s5_t2", (req_cyc.size() > 1 && done_cyc.size() > 0) ?
              req_cyc[1] - done_cyc[0] : -1, 100);
        wait_done("s5_done2", 500);
        autosave_en = 0;
        tick(2);

        // reset in the middle of an 8-sector save
        ram_mask = 24'hFFF;
        clear_q();
        pulse_save();
        wait_reqs("s6_req3", 4, 1000);
        tick(5);
        save_req = 1;
        #2 RESET_N = 1'b0;
        #1;
        check("s6_lba", sd_m.lba, 0);
        check("s6_wr", sd_m.wr, 0);
        check("s6_rd", sd_m.rd, 0);
        check("s6_busy", busy_m, 0);
        check("s6_done", done_m, 0);
        ack_en_m = 0;
        tick(30);
        RESET_N = 1'b1;
        tick(100);
        check("s6_noreq", req_lba.size(), 4);
        check("s6_nodone", done_cyc.size(), 0);
        check("s6_idle", busy_m, 0);
        save_req = 0;
        ack_en_m = 1;
        tick(2);
        save_req = 1;
        wait_done("s6_rearm", 2000);
        tick(2);
        save_req = 0;
        check("s6_rearm_cnt", req_lba.size(), 12);

        // no backup RAM
        ram_mask = '0;
        clear_q();
        pulse_save();
        tick(40);
        check("mask0_idle", req_lba.size(), 0);

        for (int i = 0; i < 8; i++) begin
            logic [23:0] m;
            bit sv, en;
            m  = 24'($urandom_range(0, 32'h1FFF));
            sv = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 3) != 0);
            ena_m = en;
            ram_mask = m;
            clear_q();
            if (sv) pulse_save();
            else pulse_load();
            if (en && m != 0) begin
                wait_done("rnd_done", 2000);
                tick(2);
                check_xfer("rnd", m, sv);
            end else begin
                tick(60);
                check("rnd_idle", req_lba.size(), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
